// File: rtl/baud_tick_gen.sv
// Baud tick generator for a UART.
// Produces the TX bit tick and the RX oversample, mid-bit and end-of-bit ticks.
// A new divisor is held as pending and applied to TX and RX separately, each
// only while its side is idle, so a frame in flight never changes rate.
module baud_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int OVS         = 16,
    parameter int DEFAULT_DIV = 5208
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_divisor,
    input  logic             div_load,
    input  logic             tx_idle,
    input  logic             rx_idle,
    input  logic             rx_resync,
    output logic             tx_tick,
    output logic             rx_os_tick,
    output logic             rx_sample_tick,
    output logic             rx_bit_tick,
    output logic [DIV_W-1:0] tx_div,
    output logic [DIV_W-1:0] rx_div,
    output logic             div_pending,
    output logic             div_err
);

    localparam int                OVS_LG  = $clog2(OVS);
    localparam logic [DIV_W-1:0]  DEF     = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W:0]    MIN_DIV = (DIV_W+1)'(2 * OVS);
    localparam logic [DIV_W-1:0]  ONE     = DIV_W'(1);
    localparam logic [OVS_LG-1:0] PH_ONE  = OVS_LG'(1);
    localparam logic [OVS_LG-1:0] PH_MID  = OVS_LG'(OVS / 2 - 1);
    localparam logic [OVS_LG-1:0] PH_LAST = OVS_LG'(OVS - 1);

    // Divisor control state
    logic [DIV_W-1:0]  pend_q;
    logic              pend_tx_q, pend_rx_q;
    logic              pend_tx_d, pend_rx_d;
    logic [DIV_W-1:0]  tx_div_q, rx_div_q;
    logic              div_pending_q, div_err_q;

    // Timing state
    logic [DIV_W-1:0]  tx_cnt_q;
    logic [DIV_W-1:0]  os_cnt_q;
    logic [OVS_LG-1:0] phase_q;
    logic              tx_tick_q, os_tick_q, sample_tick_q, bit_tick_q;

    logic              load_ok, load_bad;
    logic              tx_apply, rx_apply;
    logic [DIV_W-1:0]  os_div;
    logic              tx_wrap, os_wrap;

    // Divisors below 2*OVS would give an oversample period under two cycles.
    assign load_ok  = div_load && ({1'b0, baud_divisor} >= MIN_DIV);
    assign load_bad = div_load && !load_ok;

    // Applies read the old pending value; a coincident load re-arms both flags.
    assign tx_apply  = pend_tx_q && tx_idle;
    assign rx_apply  = pend_rx_q && rx_idle;
    assign pend_tx_d = load_ok || (pend_tx_q && !tx_idle);
    assign pend_rx_d = load_ok || (pend_rx_q && !rx_idle);

    assign os_div  = rx_div_q >> OVS_LG;
    assign tx_wrap = (tx_cnt_q == tx_div_q - ONE);
    assign os_wrap = (os_cnt_q == os_div - ONE);

    // Pending divisor latch, per-side apply and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= DEF;
            pend_tx_q     <= 1'b0;
            pend_rx_q     <= 1'b0;
            tx_div_q      <= DEF;
            rx_div_q      <= DEF;
            div_pending_q <= 1'b0;
            div_err_q     <= 1'b0;
        end else begin
            if (load_ok)  pend_q   <= baud_divisor;
            if (tx_apply) tx_div_q <= pend_q;
            if (rx_apply) rx_div_q <= pend_q;
            pend_tx_q     <= pend_tx_d;
            pend_rx_q     <= pend_rx_d;
            div_pending_q <= pend_tx_d || pend_rx_d;
            div_err_q     <= load_bad;
        end
    end

    // TX bit counter; restarts from zero when a new divisor is applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q  <= '0;
            tx_tick_q <= 1'b0;
        end else if (tx_apply) begin
            tx_cnt_q  <= '0;
            tx_tick_q <= 1'b0;
        end else if (tx_wrap) begin
            tx_cnt_q  <= '0;
            tx_tick_q <= 1'b1;
        end else begin
            tx_cnt_q  <= tx_cnt_q + ONE;
            tx_tick_q <= 1'b0;
        end
    end

    // RX oversample counter and bit phase; resync or apply restarts the bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q      <= '0;
            phase_q       <= '0;
            os_tick_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            bit_tick_q    <= 1'b0;
        end else if (rx_apply || rx_resync) begin
            os_cnt_q      <= '0;
            phase_q       <= '0;
            os_tick_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            bit_tick_q    <= 1'b0;
        end else if (os_wrap) begin
            os_cnt_q      <= '0;
            phase_q       <= phase_q + PH_ONE;
            os_tick_q     <= 1'b1;
            sample_tick_q <= (phase_q == PH_MID);
            bit_tick_q    <= (phase_q == PH_LAST);
        end else begin
            os_cnt_q      <= os_cnt_q + ONE;
            os_tick_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            bit_tick_q    <= 1'b0;
        end
    end

    assign tx_tick        = tx_tick_q;
    assign rx_os_tick     = os_tick_q;
    assign rx_sample_tick = sample_tick_q;
    assign rx_bit_tick    = bit_tick_q;
    assign tx_div         = tx_div_q;
    assign rx_div         = rx_div_q;
    assign div_pending    = div_pending_q;
    assign div_err        = div_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with DEFAULT_DIV=64, OVS=16.
// Inputs change and outputs are sampled on the falling edge; "edge N" below
// is the Nth rising edge after reset release.
module tb_baud_tick_gen;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] baud_divisor;
    logic             div_load, tx_idle, rx_idle, rx_resync;
    logic             tx_tick, rx_os_tick, rx_sample_tick, rx_bit_tick;
    logic [DIV_W-1:0] tx_div, rx_div;
    logic             div_pending, div_err;

    int total = 0;
    int fails = 0;

    baud_tick_gen #(.DIV_W(DIV_W), .OVS(16), .DEFAULT_DIV(64)) dut (
        .clk(clk), .rst_n(rst_n), .baud_divisor(baud_divisor),
        .div_load(div_load), .tx_idle(tx_idle), .rx_idle(rx_idle),
        .rx_resync(rx_resync), .tx_tick(tx_tick), .rx_os_tick(rx_os_tick),
        .rx_sample_tick(rx_sample_tick), .rx_bit_tick(rx_bit_tick),
        .tx_div(tx_div), .rx_div(rx_div), .div_pending(div_pending),
        .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; baud_divisor = '0; div_load = 1'b0;
        tx_idle = 1'b1; rx_idle = 1'b1; rx_resync = 1'b0;
        adv(2);
        chk("rst tx_div", tx_div, 64);
        chk("rst rx_div", rx_div, 64);
        chk("rst pending", div_pending, 0);
        chk("rst ticks", {tx_tick, rx_os_tick, rx_sample_tick, rx_bit_tick, div_err}, 0);
        rst_n = 1'b1;

        // Free-running timing from reset release
        adv(3);  chk("os tick e3", rx_os_tick, 0);
        adv(1);  chk("os tick e4", rx_os_tick, 1);
        adv(1);  chk("os tick e5", rx_os_tick, 0);
        adv(3);  chk("os tick e8", rx_os_tick, 1);
        adv(23); chk("sample e31", rx_sample_tick, 0);
        adv(1);  chk("sample e32", rx_sample_tick, 1);
        chk("bit e32", rx_bit_tick, 0);
        adv(31); chk("tx tick e63", tx_tick, 0);
        chk("bit e63", rx_bit_tick, 0);
        adv(1);  chk("tx tick e64", tx_tick, 1);
        chk("bit e64", rx_bit_tick, 1);
        adv(1);  chk("tx tick e65", tx_tick, 0);
        adv(63); chk("tx tick e128", tx_tick, 1);

        // Resync at edge 172 (phase 10, where an os tick would fire)
        adv(43); rx_resync = 1'b1;
        adv(1);  rx_resync = 1'b0;
        chk("resync os", rx_os_tick, 0);
        chk("resync sample", rx_sample_tick, 0);
        adv(4);  chk("resync os +4", rx_os_tick, 1);
        adv(27); chk("resync sample +31", rx_sample_tick, 0);
        adv(1);  chk("resync sample +32", rx_sample_tick, 1);

        // Rejected divisor
        baud_divisor = 16'd31; div_load = 1'b1;
        adv(1);  div_load = 1'b0;
        chk("err pulse", div_err, 1);
        chk("err pending", div_pending, 0);
        chk("err tx_div", tx_div, 64);
        chk("err rx_div", rx_div, 64);
        adv(1);  chk("err clears", div_err, 0);

        // Load 128 while TX busy: RX applies, TX waits for idle
        tx_idle = 1'b0; baud_divisor = 16'd128; div_load = 1'b1;
        adv(1);  div_load = 1'b0;
        chk("ld pending", div_pending, 1);
        chk("ld rx_div old", rx_div, 64);
        adv(1);  chk("rx applied", rx_div, 128);
        chk("tx held", tx_div, 64);
        chk("still pending", div_pending, 1);
        adv(5);  chk("tx held +5", tx_div, 64);
        tx_idle = 1'b1;
        adv(1);  chk("tx applied", tx_div, 128);
        chk("pending falls", div_pending, 0);

        // Load 96 on the same edge a pending-128 TX apply happens
        tx_idle = 1'b0; baud_divisor = 16'd128; div_load = 1'b1;
        adv(1);  div_load = 1'b0;
        adv(1);  chk("rx 128 again", rx_div, 128);
        tx_idle = 1'b1; baud_divisor = 16'd96; div_load = 1'b1;
        adv(1);  div_load = 1'b0;
        chk("coincide tx_div", tx_div, 128);
        chk("coincide pending", div_pending, 1);
        adv(1);  chk("96 tx", tx_div, 96);
        chk("96 rx", rx_div, 96);
        chk("96 pending", div_pending, 0);

        // Asynchronous reset with a divisor pending
        tx_idle = 1'b0; rx_idle = 1'b0; baud_divisor = 16'd200; div_load = 1'b1;
        adv(1);  div_load = 1'b0;
        chk("pre-rst pending", div_pending, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async tx_div", tx_div, 64);
        chk("async rx_div", rx_div, 64);
        chk("async pending", div_pending, 0);
        chk("async ticks", {tx_tick, rx_os_tick, rx_sample_tick, rx_bit_tick, div_err}, 0);
        adv(1);  rst_n = 1'b1; tx_idle = 1'b1; rx_idle = 1'b1;
        adv(2);  chk("discard tx_div", tx_div, 64);
        chk("discard rx_div", rx_div, 64);
        chk("discard pending", div_pending, 0);
        adv(1);  chk("post-rst os e3", rx_os_tick, 0);
        adv(1);  chk("post-rst os e4", rx_os_tick, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
